// File: rtl/controle_escrita_banco_if.sv
// Write-request bundle: ALU and memory writeback sources into the bank write controller.
// Latency: wires only; a request is taken on the rising edge where valid && ready.
// Backpressure: ready low holds the source; reg/data must stay stable while valid waits.
//
// Ports (signals): alu_valid/alu_ready/alu_reg/alu_data, mem_valid/mem_ready/mem_reg/mem_data.
// master = request source, slave = write controller.
interface controle_escrita_banco_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output alu_valid, alu_reg, alu_data,
        input  alu_ready,
        output mem_valid, mem_reg, mem_data,
        input  mem_ready
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        output alu_ready,
        input  mem_valid, mem_reg, mem_data,
        output mem_ready
    );
endinterface

// File: rtl/controle_escrita_banco.sv
// Write-side initiator for the 8x16 register bank: arbitrates ALU/MEM writebacks into an in-order FIFO.
// Latency: accepted at edge N, RegWrite pulse during cycle N+1, bank updated at edge N+2; 1 write/cycle.
// Backpressure: ready drops when the FIFO is full (start-of-cycle count); stall only holds the drain.
//
// Ports: clock, resetn (async, active low); req (ALU/MEM valid-ready requests, slave side);
// stall; WriteReg/WriteData/RegWrite to the bank; Read1/Read2 + Data1_rf/Data2_rf from the bank;
// Data1/Data2 + fwd1/fwd2 forwarded read values; count = FIFO occupancy.
module controle_escrita_banco #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clock,
    input  logic                                 resetn,
    controle_escrita_banco_if.slave              req,
    input  logic                                 stall,
    output logic [ADDR_W-1:0]                    WriteReg,
    output logic [DATA_W-1:0]                    WriteData,
    output logic                                 RegWrite,
    input  logic [ADDR_W-1:0]                    Read1,
    input  logic [ADDR_W-1:0]                    Read2,
    input  logic [DATA_W-1:0]                    Data1_rf,
    input  logic [DATA_W-1:0]                    Data2_rf,
    output logic [DATA_W-1:0]                    Data1,
    output logic [DATA_W-1:0]                    Data2,
    output logic                                 fwd1,
    output logic                                 fwd2,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    // Arbitration priority state.
    localparam logic PRIO_ALU = 1'b0;
    localparam logic PRIO_MEM = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] dat;
    } entry_t;

    entry_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               prio;

    logic               full;
    logic               push_alu;
    logic               push_mem;
    logic               push;
    logic               pop;
    logic               contested;
    entry_t             push_entry;

    // Full is taken from start-of-cycle occupancy, so a same-edge pop never frees a slot for a push.
    assign full = (count == CNT_W'(FIFO_DEPTH));

    // Readies are gated by resetn so no handshake can complete while reset is asserted.
    assign req.alu_ready = resetn && !full && (!req.mem_valid || prio == PRIO_ALU);
    assign req.mem_ready = resetn && !full && (!req.alu_valid || prio == PRIO_MEM);

    assign push_alu   = req.alu_valid && req.alu_ready;
    assign push_mem   = req.mem_valid && req.mem_ready;
    assign push       = push_alu || push_mem;
    assign push_entry = push_alu ? entry_t'{req.alu_reg, req.alu_data}
                                 : entry_t'{req.mem_reg, req.mem_data};
    assign pop        = !stall && (count != '0);
    assign contested  = req.alu_valid && req.mem_valid && !full;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            prio      <= PRIO_ALU;
            WriteReg  <= '0;
            WriteData <= '0;
            RegWrite  <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_entry;
                wr_ptr           <= wr_ptr + 1'b1;
            end

            // No bypass: an entry pushed on this edge is only visible to pop on the next one.
            if (pop) begin
                WriteReg  <= fifo_mem[rd_ptr].idx;
                WriteData <= fifo_mem[rd_ptr].dat;
                rd_ptr    <= rd_ptr + 1'b1;
                RegWrite  <= 1'b1;
            end else begin
                RegWrite  <= 1'b0;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // The winner of a contested grant hands priority to the loser.
            if (contested) begin
                prio <= ~prio;
            end
        end
    end

    // Forwarding: scan from oldest to newest so the last match (newest) wins.
    // The output stage is older than anything still in the FIFO.
    always_comb begin
        Data1 = Data1_rf;
        fwd1  = 1'b0;
        Data2 = Data2_rf;
        fwd2  = 1'b0;

        if (RegWrite && WriteReg == Read1) begin
            Data1 = WriteData;
            fwd1  = 1'b1;
        end
        if (RegWrite && WriteReg == Read2) begin
            Data2 = WriteData;
            fwd2  = 1'b1;
        end

        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                if (fifo_mem[rd_ptr + PTR_W'(i)].idx == Read1) begin
                    Data1 = fifo_mem[rd_ptr + PTR_W'(i)].dat;
                    fwd1  = 1'b1;
                end
                if (fifo_mem[rd_ptr + PTR_W'(i)].idx == Read2) begin
                    Data2 = fifo_mem[rd_ptr + PTR_W'(i)].dat;
                    fwd2  = 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_controle_escrita_banco.sv
// Bench for controle_escrita_banco: scoreboard of accepted writes vs. bank write port and forwarding.
// Latency: inputs driven #1 after the rising edge, outputs sampled on the falling edge.
// Backpressure: a source request is held until the reference model predicts its acceptance.
module tb_controle_escrita_banco;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  WriteReg;
    logic [15:0] WriteData;
    logic        RegWrite;
    logic [2:0]  Read1 = '0;
    logic [2:0]  Read2 = '0;
    logic [15:0] Data1_rf = '0;
    logic [15:0] Data2_rf = '0;
    logic [15:0] Data1;
    logic [15:0] Data2;
    logic        fwd1;
    logic        fwd2;
    logic [2:0]  count;

    controle_escrita_banco_if #(.ADDR_W(3), .DATA_W(16)) bus ();

    controle_escrita_banco #(.DATA_W(16), .ADDR_W(3), .FIFO_DEPTH(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req       (bus),
        .stall     (stall),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .Read1     (Read1),
        .Read2     (Read2),
        .Data1_rf  (Data1_rf),
        .Data2_rf  (Data2_rf),
        .Data1     (Data1),
        .Data2     (Data2),
        .fwd1      (fwd1),
        .fwd2      (fwd2),
        .count     (count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] d;
    } ent_t;

    // sb: writes accepted but not yet seen on the write port, oldest first.
    ent_t sb[$];
    ent_t aq[$];
    ent_t mq[$];
    int   gq[$];

    int   total = 0;
    int   bad = 0;

    int          m_count;
    logic        m_prio;
    logic        m_rw;
    logic [2:0]  m_wreg;
    logic [15:0] m_wdata;
    logic        acc_alu;
    logic        acc_mem;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        sb.delete();
        m_count = 0;
        m_prio  = 1'b0;
        m_rw    = 1'b0;
        m_wreg  = '0;
        m_wdata = '0;
        acc_alu = 1'b0;
        acc_mem = 1'b0;
    endtask

    // One clock: check outputs on the falling edge, predict acceptance, advance the model on the rising edge.
    task automatic step();
        logic [15:0] e1;
        logic [15:0] e2;
        logic        f1;
        logic        f2;
        logic        full;
        logic        pop;
        ent_t        e;
        Data1_rf = 16'($urandom);
        Data2_rf = 16'($urandom);
        @(negedge clock);
        e1 = Data1_rf;
        f1 = 1'b0;
        e2 = Data2_rf;
        f2 = 1'b0;
        foreach (sb[i]) begin
            if (sb[i].r == Read1) begin
                e1 = sb[i].d;
                f1 = 1'b1;
            end
            if (sb[i].r == Read2) begin
                e2 = sb[i].d;
                f2 = 1'b1;
            end
        end
        chk("fwd1", fwd1, f1);
        chk("data1", Data1, e1);
        chk("fwd2", fwd2, f2);
        chk("data2", Data2, e2);
        chk("regwrite", RegWrite, m_rw);
        if (m_rw && sb.size() > 0) begin
            e = sb.pop_front();
            m_wreg  = e.r;
            m_wdata = e.d;
        end
        chk("writereg", WriteReg, m_wreg);
        chk("writedata", WriteData, m_wdata);
        chk("count", count, m_count);

        full    = (m_count == 4);
        acc_alu = bus.alu_valid && !full && (!bus.mem_valid || !m_prio);
        acc_mem = bus.mem_valid && !full && (!bus.alu_valid || m_prio);
        chk("alu_ready", bus.alu_ready, !full && (!bus.mem_valid || !m_prio));
        chk("mem_ready", bus.mem_ready, !full && (!bus.alu_valid || m_prio));
        gq.push_back((bus.alu_valid && bus.alu_ready) ? 1 : ((bus.mem_valid && bus.mem_ready) ? 2 : 0));
        if (acc_alu) sb.push_back({bus.alu_reg, bus.alu_data});
        else if (acc_mem) sb.push_back({bus.mem_reg, bus.mem_data});

        @(posedge clock);
        pop = !stall && (m_count > 0);
        if (bus.alu_valid && bus.mem_valid && !full) m_prio = !m_prio;
        m_count = m_count + (acc_alu || acc_mem ? 1 : 0) - (pop ? 1 : 0);
        m_rw = pop;
        #1;
    endtask

    // Present queued requests for up to n cycles; a request advances only when accepted.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            bus.alu_valid = (aq.size() > 0);
            bus.mem_valid = (mq.size() > 0);
            if (aq.size() > 0) {bus.alu_reg, bus.alu_data} = aq[0];
            if (mq.size() > 0) {bus.mem_reg, bus.mem_data} = mq[0];
            step();
            if (acc_alu) void'(aq.pop_front());
            if (acc_mem) void'(mq.pop_front());
        end
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((m_count != 0 || m_rw) && k < 20) begin
            step();
            k++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        bus.alu_valid = 1'b1;
        bus.mem_valid = 1'b1;
        bus.alu_reg   = 3'd1;
        bus.alu_data  = 16'h1111;
        bus.mem_reg   = 3'd5;
        bus.mem_data  = 16'h5555;

        // Reset with both sources requesting.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_writereg", WriteReg, 0);
        chk("rst_writedata", WriteData, 0);
        chk("rst_count", count, 0);
        chk("rst_alu_ready", bus.alu_ready, 0);
        chk("rst_mem_ready", bus.mem_ready, 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Contention: alternate grants starting with ALU; includes a write to r0.
        aq.push_back({3'd1, 16'h1111});
        aq.push_back({3'd2, 16'h2222});
        aq.push_back({3'd3, 16'h3333});
        aq.push_back({3'd4, 16'h4444});
        mq.push_back({3'd5, 16'h5555});
        mq.push_back({3'd6, 16'h6666});
        mq.push_back({3'd0, 16'hBEEF});
        mq.push_back({3'd7, 16'h7777});
        gq.delete();
        Read1 = 3'd0;
        Read2 = 3'd2;
        run(4);
        chk("grant0", gq[0], 1);
        chk("grant1", gq[1], 2);
        chk("grant2", gq[2], 1);
        chk("grant3", gq[3], 2);
        run(8);
        drain();

        // Single write with forwarding through FIFO then output stage.
        Read1 = 3'd3;
        aq.push_back({3'd3, 16'h1234});
        run(1);
        chk("single_fwd1_fifo", fwd1, 1);
        chk("single_data1_fifo", Data1, 16'h1234);
        step();
        chk("single_fwd1_out", fwd1, 1);
        chk("single_data1_out", Data1, 16'h1234);
        chk("single_wreg", WriteReg, 3);
        step();
        chk("single_fwd1_done", fwd1, 0);
        drain();

        // Stall until full, then release.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) aq.push_back({3'(i + 1), 16'hA000 + 16'(i)});
        run(6);
        chk("full_count", count, 4);
        bus.alu_valid = 1'b1;
        {bus.alu_reg, bus.alu_data} = aq[0];
        #1;
        chk("full_alu_ready", bus.alu_ready, 0);
        stall = 1'b0;
        run(8);
        drain();

        // Newest pending write wins.
        stall = 1'b1;
        Read2 = 3'd5;
        aq.push_back({3'd5, 16'h0001});
        aq.push_back({3'd5, 16'h0002});
        run(2);
        Data2_rf = 16'hFFFF;
        #1;
        chk("newest_data2", Data2, 16'h0002);
        chk("newest_fwd2", fwd2, 1);
        stall = 1'b0;
        drain();

        // Asynchronous reset in the middle of a drain.
        stall = 1'b1;
        aq.push_back({3'd1, 16'hC001});
        aq.push_back({3'd2, 16'hC002});
        aq.push_back({3'd4, 16'hC004});
        run(3);
        stall = 1'b0;
        run(1);
        chk("mid_regwrite_before", RegWrite, 1);
        #1;
        resetn = 1'b0;
        #1;
        chk("mid_regwrite", RegWrite, 0);
        chk("mid_count", count, 0);
        chk("mid_writereg", WriteReg, 0);
        chk("mid_writedata", WriteData, 0);
        chk("mid_alu_ready", bus.alu_ready, 0);
        #1;
        resetn = 1'b1;
        m_reset();
        run(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/controle_escrita_banco.md
Name: controle_escrita_banco

Overview:
Write-side initiator for the 8x16 register bank. It accepts writeback requests from the ALU and memory paths over valid/ready handshakes and arbitrates between them. Accepted writes are buffered in a small in-order FIFO and drained one per cycle onto the bank's WriteReg/WriteData/RegWrite port. It also forwards pending (not yet committed) write data onto the datapath read values, so reads always see the newest value.

Parameters:
DATA_W, 16, data width; matches the bank word.
ADDR_W, 3, register index width (8 registers).
FIFO_DEPTH, 4, pending-write buffer depth; power of 2, >= 2.

Ports:
clock  in  1  system clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
alu_valid  in  1  ALU write request.
alu_ready  out  1  ALU request accepted this edge when high with alu_valid.
alu_reg  in  ADDR_W  ALU destination index.
alu_data  in  DATA_W  ALU result.
mem_valid  in  1  memory-load write request.
mem_ready  out  1  memory request accepted this edge when high with mem_valid.
mem_reg  in  ADDR_W  load destination index.
mem_data  in  DATA_W  load data.
stall  in  1  hold drain; no bank write issued while high.
WriteReg  out  ADDR_W  to bank write index.
WriteData  out  DATA_W  to bank write data.
RegWrite  out  1  to bank write enable.
Read1, Read2  in  ADDR_W  read indices, same as those driven to the bank.
Data1_rf, Data2_rf  in  DATA_W  raw bank read data.
Data1, Data2  out  DATA_W  forwarded read data for the datapath.
fwd1, fwd2  out  1  high when Data1/Data2 comes from a pending write.
count  out  clog2(FIFO_DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (resetn=0, async): FIFO emptied and count=0. RegWrite=0, WriteReg=0, WriteData=0 immediately. prio=ALU. alu_ready and mem_ready are forced 0 while reset is asserted. Reset mid-drain discards all pending writes, and no RegWrite pulse follows.
- full = (count==FIFO_DEPTH), evaluated on start-of-cycle state. A same-cycle pop does not free a slot for a push.
- Arbitration: one push per cycle, maximum.
  - alu_ready = !full && (!mem_valid || prio==ALU).
  - mem_ready = !full && (!alu_valid || prio==MEM).
  - prio toggles to the losing source only on a contested grant (both valid, not full). Uncontested grants leave prio unchanged.
- Push: on a rising edge with valid&ready, {reg,data} is written at the FIFO tail.
- Writes to index 0 are ordinary writes; r0 is not hardwired.
- Drain: on each rising edge:
  - If stall=0 and count>0, pop the head into the registered WriteReg/WriteData and set RegWrite=1.
  - Otherwise RegWrite=0; WriteReg/WriteData hold their last values.
- RegWrite is a one-cycle pulse per write. Back-to-back pops give continuous RegWrite with a new index/data each cycle. Writes reach the bank in exact acceptance order.
- Latency: accepted at edge N, popped at edge N+1 (RegWrite high in cycle N+1), bank updated at edge N+2. There is no FIFO bypass: a push into an empty FIFO is not popped on the same edge. Throughput is 1 write/cycle.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Forwarding (combinational):
  - Candidates for Data1: the output stage (RegWrite=1 && WriteReg==Read1) and every valid FIFO entry whose reg==Read1.
  - Age order, newest first: FIFO tail-most entry, then older FIFO entries, then the output stage.
  - The newest match drives Data1 with fwd1=1. With no match, Data1=Data1_rf and fwd1=0.
  - Data2 is identical, using Read2/Data2_rf.
- stall affects only the drain; pushes continue until full.

Test Plan:
- Reset: hold resetn=0 with both valids high -> RegWrite=0, WriteReg=0, WriteData=0, count=0, alu_ready=mem_ready=0. Release -> alu_ready=1 first (prio ALU).
- Single write: ALU r3=0x1234 accepted at edge N -> RegWrite=1, WriteReg=3, WriteData=0x1234 during cycle N+1 only. With Read1=3: Data1=0x1234, fwd1=1 in cycles N and N+1. From N+2, fwd1=0 and bank data is used.
- Contention: both valid for 4 cycles (ALU r1..r4, MEM r5..) -> grants ALU, MEM, ALU, MEM. Write port order is r1, r5, r2, r6.
- Stall/full: stall=1, 5 ALU writes -> 4 accepted, count=4, alu_ready=0. stall=0 -> 4 RegWrite pulses in order on consecutive cycles. The 5th is accepted the cycle after count first drops below 4.
- Newest forwarding: FIFO holds r5=0x0001 then r5=0x0002, Read2=5, Data2_rf=0xFFFF -> Data2=0x0002, fwd2=1.
- Async reset mid-drain: count=3, resetn pulsed low between edges -> RegWrite drops to 0 immediately, count=0, no further RegWrite after release.
